bcd_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the BCD-to-decimal decoder.

---
 rtl/bcd_scan_if.sv | 54 +++++
 rtl/bcd_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_if
//   Bundles the load handshake and the display outputs of bcd_scan_ctrl.
//   master : the load source / display consumer (drives en, load_valid,
//            load_data; observes everything else)
//   slave  : the scan controller itself
//   Signals:
//     en           scan enable (0 freezes dwell/index counters)
//     load_valid   load request
//     load_data    packed BCD word, digit i = [4i+3:4i]
//     load_ready   pending buffer empty
//     bcd_out      digit code to the decoder ({inA3,inA2,inA1,inA0})
//     digit_sel    one-hot select of the digit currently shown
//     digit_strobe 1-cycle pulse on the first dwell cycle of each digit
//     digit_err    current digit is a non-BCD code (10..15)
//     err_sticky   a non-BCD digit has been shown since the last load accept
// ---------------------------------------------------------------------------
interface bcd_scan_if #(
  parameter int NDIG = 4
);
  logic                en;
  logic                load_valid;
  logic [4*NDIG-1:0]   load_data;
  logic                load_ready;
  logic [3:0]          bcd_out;
  logic [NDIG-1:0]     digit_sel;
  logic                digit_strobe;
  logic                digit_err;
  logic                err_sticky;

  modport master (
    output en,
    output load_valid,
    output load_data,
    input  load_ready,
    input  bcd_out,
    input  digit_sel,
    input  digit_strobe,
    input  digit_err,
    input  err_sticky
  );

  modport slave (
    input  en,
    input  load_valid,
    input  load_data,
    output load_ready,
    output bcd_out,
    output digit_sel,
    output digit_strobe,
    output digit_err,
    output err_sticky
  );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_scan_ctrl
//   Time-multiplexed scan controller for a BCD-to-decimal decoder. Holds an
//   NDIG-digit packed BCD word and presents one digit at a time, DWELL clock
//   cycles per digit, with a one-hot digit select and a per-digit strobe.
//   New words enter through a 1-deep pending buffer and are only promoted to
//   the displayed word at a frame boundary, so a frame never mixes two words.
//
//   Parameters:
//     NDIG   number of BCD digits per frame (>=2), digit 0 least significant
//     DWELL  clock cycles each digit is held (>=1)
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    bcd_scan_if.slave (en, load handshake, display outputs)
//
//   Optional build macro:
//     BCD_LZ_BLANK_EN  leading-zero blanking. Digits above the most
//                      significant non-zero digit keep their time slot and
//                      strobe but show digit_sel=0 and bcd_out=4'hF. Digit 0
//                      is never blanked.
// ---------------------------------------------------------------------------
module bcd_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  bcd_scan_if.slave bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int WW = 4 * NDIG;
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [NDIG-1:0] SEL_ONE  = NDIG'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Extract BCD digit i from a packed word.
  function automatic logic [3:0] digit_of(input logic [WW-1:0] word,
                                          input logic [IW-1:0] i);
    return word[{i, 2'b00} +: 4];
  endfunction

`ifdef BCD_LZ_BLANK_EN
  // Index of the most significant non-zero digit; 0 for an all-zero word so
  // that digit 0 always stays visible.
  function automatic logic [IW-1:0] msd_of(input logic [WW-1:0] word);
    logic [IW-1:0] m;
    m = '0;
    for (int k = 1; k < NDIG; k++) begin
      m = (word[4*k +: 4] != 4'd0) ? IW'(k) : m;
    end
    return m;
  endfunction
`endif

  // Registered state
  state_t          state_r;
  logic [WW-1:0]   active_r;
  logic [WW-1:0]   pend_r;
  logic            pend_valid_r;
  logic [IW-1:0]   idx_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      bcd_out_r;
  logic [NDIG-1:0] digit_sel_r;
  logic            digit_strobe_r;
  logic            digit_err_r;
  logic            err_sticky_r;

  // Next-state terms
  logic            accept_s;
  logic            start_s;
  logic            advance_s;
  logic            cnt_wrap_s;
  logic            frame_end_s;
  logic            take_s;
  logic [CW-1:0]   cnt_n_s;
  logic [IW-1:0]   idx_n_s;
  logic [WW-1:0]   word_s;
  logic [3:0]      code_s;
  logic            blank_s;
  logic [3:0]      bcd_n_s;
  logic [NDIG-1:0] sel_n_s;
  logic            strobe_n_s;
  logic            err_n_s;
  logic            sticky_n_s;

  assign bus.load_ready   = ~pend_valid_r;
  assign bus.bcd_out      = bcd_out_r;
  assign bus.digit_sel    = digit_sel_r;
  assign bus.digit_strobe = digit_strobe_r;
  assign bus.digit_err    = digit_err_r;
  assign bus.err_sticky   = err_sticky_r;

  // Handshake, scan counters and the next displayed digit.
  always_comb begin
    accept_s    = bus.load_valid && !pend_valid_r;
    start_s     = (state_r == ST_IDLE) && pend_valid_r;
    advance_s   = (state_r == ST_SCAN) && bus.en;
    cnt_wrap_s  = (cnt_r == CNT_LAST);
    frame_end_s = cnt_wrap_s && (idx_r == IDX_LAST);
    // Pending word is promoted on IDLE exit or at an enabled frame boundary;
    // accept_s needs !pend_valid_r so the two can never collide.
    take_s      = pend_valid_r && (start_s || (advance_s && frame_end_s));

    if (start_s) begin
      cnt_n_s = '0;
      idx_n_s = '0;
    end else if (advance_s) begin
      if (cnt_wrap_s) begin
        cnt_n_s = '0;
        idx_n_s = (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
      end else begin
        cnt_n_s = cnt_r + 1'b1;
        idx_n_s = idx_r;
      end
    end else begin
      cnt_n_s = cnt_r;
      idx_n_s = idx_r;
    end

    // Digit about to be shown comes from the word that will be active
    // after this edge, so a new word starts cleanly at digit 0.
    word_s = take_s ? pend_r : active_r;
    code_s = digit_of(word_s, idx_n_s);
`ifdef BCD_LZ_BLANK_EN
    blank_s = (idx_n_s > msd_of(word_s));
`else
    blank_s = 1'b0;
`endif

    if (start_s || advance_s) begin
      strobe_n_s = (cnt_n_s == '0);
      if (blank_s) begin
        bcd_n_s = 4'hF;
        sel_n_s = '0;
        err_n_s = 1'b0;
      end else begin
        bcd_n_s = code_s;
        sel_n_s = SEL_ONE << idx_n_s;
        err_n_s = (code_s > 4'd9);
      end
    end else if (state_r == ST_SCAN) begin
      // Frozen by en=0: hold the display, suppress the strobe.
      strobe_n_s = 1'b0;
      bcd_n_s    = bcd_out_r;
      sel_n_s    = digit_sel_r;
      err_n_s    = digit_err_r;
    end else begin
      strobe_n_s = 1'b0;
      bcd_n_s    = 4'd0;
      sel_n_s    = '0;
      err_n_s    = 1'b0;
    end

    // A load accept clears the sticky flag even if an error shows that cycle.
    sticky_n_s = accept_s ? 1'b0 : (err_sticky_r | err_n_s);
  end

  // Scan FSM, pending buffer and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      active_r       <= '0;
      pend_r         <= '0;
      pend_valid_r   <= 1'b0;
      idx_r          <= '0;
      cnt_r          <= '0;
      bcd_out_r      <= 4'd0;
      digit_sel_r    <= '0;
      digit_strobe_r <= 1'b0;
      digit_err_r    <= 1'b0;
      err_sticky_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= start_s ? ST_SCAN : ST_IDLE;
        ST_SCAN: state_r <= ST_SCAN;
        default: state_r <= ST_IDLE;
      endcase

      if (take_s) begin
        active_r     <= pend_r;
        pend_valid_r <= 1'b0;
      end else if (accept_s) begin
        pend_r       <= bus.load_data;
        pend_valid_r <= 1'b1;
      end else begin
        pend_valid_r <= pend_valid_r;
      end

      idx_r          <= idx_n_s;
      cnt_r          <= cnt_n_s;
      bcd_out_r      <= bcd_n_s;
      digit_sel_r    <= sel_n_s;
      digit_strobe_r <= strobe_n_s;
      digit_err_r    <= err_n_s;
      err_sticky_r   <= sticky_n_s;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_ctrl
//   Scoreboard bench for bcd_scan_ctrl (NDIG=4, DWELL=3). Stimulus pushes the
//   hand-written digit sequence it expects; a monitor pops one entry on every
//   digit_strobe and also checks the enabled-cycle spacing between strobes.
// ---------------------------------------------------------------------------
module tb_bcd_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DWELL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  bcd_scan_if #(.NDIG(NDIG)) bus ();

  bcd_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      code;
    logic [NDIG-1:0] sel;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic en_at_edge = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input logic [3:0] code, input logic [NDIG-1:0] sel, input logic err);
    exp_t e;
    e.code = code;
    e.sel  = sel;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic push_1234();
    push_ev(4'h4, 4'b0001, 1'b0);
    push_ev(4'h3, 4'b0010, 1'b0);
    push_ev(4'h2, 4'b0100, 1'b0);
    push_ev(4'h1, 4'b1000, 1'b0);
  endtask

  task automatic push_5678();
    push_ev(4'h8, 4'b0001, 1'b0);
    push_ev(4'h7, 4'b0010, 1'b0);
    push_ev(4'h6, 4'b0100, 1'b0);
    push_ev(4'h5, 4'b1000, 1'b0);
  endtask

  // Enable as seen by the DUT at each rising edge.
  always @(posedge clk) en_at_edge <= bus.en;

  // Monitor: compare each strobed digit against the scoreboard.
  int  gap;
  bit  have_prev;
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      have_prev = 1'b0;
      gap       = 0;
    end else begin
      if (en_at_edge) gap++;
      if (bus.digit_strobe) begin
        if (have_prev) check("dwell_gap", gap, DWELL);
        have_prev = 1'b1;
        gap       = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("bcd_out", bus.bcd_out, e.code);
          check("digit_sel", bus.digit_sel, e.sel);
          check("digit_err", bus.digit_err, e.err);
        end
      end
    end
  end

  task automatic wait_q(input int lim, input string what);
    int k = 0;
    while (exp_q.size() > lim && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (exp_q.size() > lim) begin
      errors++;
      $display("FAIL %s: scoreboard still holds %0d entries, required <= %0d", what, exp_q.size(), lim);
      exp_q.delete();
    end
  endtask

  task automatic do_load(input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    while (bus.load_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL load_wait: load_ready stuck at %0b, required 1", bus.load_ready);
    end
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bcd_out"},      bus.bcd_out, 4'd0);
    check({tag, "_digit_sel"},    bus.digit_sel, 4'd0);
    check({tag, "_digit_strobe"}, bus.digit_strobe, 1'b0);
    check({tag, "_digit_err"},    bus.digit_err, 1'b0);
    check({tag, "_err_sticky"},   bus.err_sticky, 1'b0);
    check({tag, "_load_ready"},   bus.load_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en         = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = 16'h0000;

    // Power-on reset
    #1 rst_n = 1'b0;
    #3;
    check_zero_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_sel", bus.digit_sel, 4'd0);

    // 1234 from IDLE, two full frames
    push_1234();
    push_1234();
    do_load(16'h1234);
    wait_q(0, "scan_1234");

    // Reset mid-SCAN with a word pending: aborts immediately, pending dropped
    do_load(16'h9999);
    check("pend_ready", bus.load_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_sel", bus.digit_sel, 4'd0);
    end

    // 5678 loaded mid-frame of 1234: held until the frame boundary
    push_1234();
    do_load(16'h1234);
    wait_q(2, "frame_1234_head");
    push_5678();
    push_5678();
    do_load(16'h5678);
    check("midframe_ready0", bus.load_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("midframe_ready_hold", bus.load_ready, 1'b0);
    wait_q(0, "scan_5678");
    check("boundary_ready1", bus.load_ready, 1'b1);
    pulse_reset();

    // Non-BCD digit: error flags
    push_ev(4'h4, 4'b0001, 1'b0);
    push_ev(4'hA, 4'b0010, 1'b1);
    push_ev(4'h2, 4'b0100, 1'b0);
    push_ev(4'h1, 4'b1000, 1'b0);
    do_load(16'h12A4);
    wait_q(0, "scan_12a4");
    check("sticky_set", bus.err_sticky, 1'b1);
    check("err_clear_d3", bus.digit_err, 1'b0);
    push_1234();
    do_load(16'h1234);
    check("sticky_clr", bus.err_sticky, 1'b0);
    wait_q(0, "scan_after_err");
    check("sticky_stays_clr", bus.err_sticky, 1'b0);
    pulse_reset();

    // en=0 for 5 cycles during digit 2
    push_1234();
    do_load(16'h1234);
    wait_q(1, "reach_digit2");
    bus.en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("freeze_hold", {bus.bcd_out, bus.digit_sel, bus.digit_strobe}, {4'h2, 4'b0100, 1'b0});
    end
    bus.en = 1'b1;
    wait_q(0, "resume_after_freeze");
    pulse_reset();

    // Zero digits: shown as zeros, or blanked above the MSD
`ifdef BCD_LZ_BLANK_EN
    push_ev(4'h0, 4'b0001, 1'b0);
    push_ev(4'h7, 4'b0010, 1'b0);
    push_ev(4'hF, 4'b0000, 1'b0);
    push_ev(4'hF, 4'b0000, 1'b0);
`else
    push_ev(4'h0, 4'b0001, 1'b0);
    push_ev(4'h7, 4'b0010, 1'b0);
    push_ev(4'h0, 4'b0100, 1'b0);
    push_ev(4'h0, 4'b1000, 1'b0);
`endif
    do_load(16'h0070);
    wait_q(0, "scan_0070");
    pulse_reset();

`ifdef BCD_LZ_BLANK_EN
    push_ev(4'h0, 4'b0001, 1'b0);
    push_ev(4'hF, 4'b0000, 1'b0);
    push_ev(4'hF, 4'b0000, 1'b0);
    push_ev(4'hF, 4'b0000, 1'b0);
`else
    push_ev(4'h0, 4'b0001, 1'b0);
    push_ev(4'h0, 4'b0010, 1'b0);
    push_ev(4'h0, 4'b0100, 1'b0);
    push_ev(4'h0, 4'b1000, 1'b0);
`endif
    do_load(16'h0000);
    wait_q(0, "scan_0000");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
